inference_sequencer: RTL
========================

// Module: inference_sequencer
// PURPOSE
//  Control FSM that schedules emotion inference runs over the phrase-buffer -> feature-register -> MLP path.
//  Fires a one-cycle start pulse. The feature registers and the valid pipeline both take this pulse.
//  Then waits for the MLP result, reports completion, and re-arms after HOP new notes (sliding-window hop).
//  Sits between the phrase buffer / enable input and the MLP valid handshake. Replaces a free-running trigger.
// PARAMETERS
//  FEAT_LAT  3    cycles from start_mlp to MLP valid_in; mlp_valid_out earlier than this is ignored
//  HOP       4    new notes required after a run before the next run may start (1..255)
//  TIMEOUT   64   max cycles from start_mlp to mlp_valid_out before abort (used only with INFER_TIMEOUT_EN)
// PORTS
//  clk            in   1  system clock
//  reset          in   1  synchronous, active-high reset
//  enable_ai      in   1  level; inference allowed while high
//  buffer_full    in   1  level; phrase buffer holds 16 valid notes
//  load_new_note  in   1  pulse; a note was shifted into the phrase buffer this cycle
//  mlp_valid_out  in   1  pulse; MLP outputs y0..y7 valid this cycle
//  start_mlp      out  1  pulse; latch features and launch valid pipeline
//  busy           out  1  high from the start_mlp cycle until the run ends
//  emotion_ready  out  1  pulse; decoded emotion valid, one cycle after the accepted mlp_valid_out
//  run_count      out  8  completed runs, wraps 255->0
//  timeout_err    out  1  sticky; an MLP run timed out
// BEHAVIOUR
//  Reset: state=IDLE. All outputs are 0. hop_cnt=0 and lat_cnt=0. Reset mid-run discards the run silently.
//  States: IDLE, START, WAIT_MLP, DONE, HOLD. Encoding is registered. All outputs are registered.
//  IDLE:  if enable_ai && buffer_full -> START. Otherwise stay.
//  START: start_mlp=1 for exactly this cycle. busy=1. lat_cnt<=1. hop_cnt<=0. -> WAIT_MLP.
//  WAIT_MLP: busy=1. lat_cnt increments and saturates at its max.
//   Accepting a result:
//   - mlp_valid_out with lat_cnt>=FEAT_LAT is accepted -> DONE.
//   - mlp_valid_out with lat_cnt<FEAT_LAT is ignored. This covers a stale result from an aborted run.
//   Abort on disable:
//   - If enable_ai falls -> IDLE, and no emotion_ready is issued.
//   - If enable_ai falls in the same cycle as an accepted mlp_valid_out, the abort wins.
//  DONE:  emotion_ready=1 for this cycle. run_count++. busy=0. -> HOLD.
//  HOLD:  wait for the next hop.
//   - If !enable_ai -> IDLE.
//   - Else if hop_cnt>=HOP && buffer_full -> START.
//   - A window that needs a fresh phrase (buffer_full low) stays in HOLD.
//  hop_cnt counting:
//   - Counts load_new_note in every state except IDLE and START.
//   - Saturates at HOP.
//   - Cleared in START and on entry to IDLE.
//   - A note arriving in the START cycle is not counted; the features latched that cycle already include it.
//  mlp_valid_out in IDLE, START, DONE or HOLD: ignored. No state change.
//  Back-to-back: the minimum spacing between start_mlp pulses is FEAT_LAT+3 cycles (START, WAIT_MLP, DONE, HOLD).
//  enable_ai and buffer_full both high out of reset: start_mlp asserts on the 2nd cycle after reset drops.
// CONFIGURATION
//  INFER_TIMEOUT_EN defined:
//   - In WAIT_MLP, when lat_cnt reaches TIMEOUT with no accepted valid: set timeout_err=1 (sticky until reset).
//   - -> HOLD with hop_cnt kept, no emotion_ready, run_count unchanged.
//   - The next run starts on the normal HOP rule.
//  INFER_TIMEOUT_EN undefined:
//   - WAIT_MLP waits indefinitely; only enable_ai low or reset exits.
//   - timeout_err is tied to 0. The TIMEOUT parameter has no effect.
// TESTING
//  T1 First run: enable=1, buffer_full=1, valid pulse 3 cycles after start_mlp.
//     Required: one start_mlp; emotion_ready 1 cycle after valid; run_count=1; busy high 4 cycles.
//  T2 Hop: after T1, pulse load_new_note 3 times -> no start_mlp.
//     4th note -> start_mlp 2 cycles after that note (hop_cnt register, then START); run_count=2 after its valid.
//  T3 Early/stray valid: valid at lat_cnt=1 is ignored (still busy). Valid while in HOLD is ignored.
//     Valid at lat_cnt=3 is accepted -> exactly one emotion_ready.
//  T4 Abort: drop enable_ai 2 cycles into WAIT_MLP -> IDLE.
//     Same-cycle enable drop + valid -> no emotion_ready, run_count unchanged.
//     Re-enable -> new start_mlp without waiting for a hop.
//  T5 Timeout (INFER_TIMEOUT_EN, TIMEOUT=8): no valid.
//     Required: timeout_err rises 8 cycles after start_mlp; busy=0; no emotion_ready; stays 1 through later runs.
//     Without the macro: busy stays high for 200 cycles; timeout_err=0.
//  T6 Reset mid-run: reset during WAIT_MLP.
//     Required: all outputs 0 next cycle; run_count=0; the following valid is ignored; timeout_err cleared.

Source files
------------

// File: rtl/inference_sequencer.sv
// Schedules emotion inference runs: start pulse, wait for the MLP result, then re-arm after HOP new notes.
// Optional MLP watchdog: define INFER_TIMEOUT_EN to abort runs that exceed TIMEOUT cycles.
module inference_sequencer #(
  parameter int FEAT_LAT = 3,
  parameter int HOP      = 4,
  parameter int TIMEOUT  = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable_ai,
  input  logic       buffer_full,
  input  logic       load_new_note,
  input  logic       mlp_valid_out,
  output logic       start_mlp,
  output logic       busy,
  output logic       emotion_ready,
  output logic [7:0] run_count,
  output logic       timeout_err
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] START    = 3'd1;
  localparam logic [2:0] WAIT_MLP = 3'd2;
  localparam logic [2:0] DONE     = 3'd3;
  localparam logic [2:0] HOLD     = 3'd4;

  // Latency counter must reach both the acceptance threshold and the watchdog limit.
  localparam int LAT_MAX = (TIMEOUT > FEAT_LAT) ? TIMEOUT : FEAT_LAT;
  localparam int LAT_W   = $clog2(LAT_MAX + 1);
  localparam logic [LAT_W-1:0] FEAT_LAT_C = LAT_W'(FEAT_LAT);
  localparam logic [7:0]       HOP_C      = 8'(HOP);

  logic [2:0]       state_q, state_d;
  logic [LAT_W-1:0] lat_cnt_q, lat_cnt_d;
  logic [7:0]       hop_cnt_q, hop_cnt_d;
  logic [7:0]       run_count_q, run_count_d;
  logic             start_q, busy_q, ready_q;
  logic             accept;
  logic             hop_counting;

  assign accept       = mlp_valid_out && (lat_cnt_q >= FEAT_LAT_C);
  assign hop_counting = (state_q != IDLE) && (state_q != START);

`ifdef INFER_TIMEOUT_EN
  localparam logic [LAT_W-1:0] TIMEOUT_LAST = LAT_W'(TIMEOUT - 1);
  logic timeout_q, timeout_d;
  logic expire;

  // Fires on the edge where lat_cnt becomes TIMEOUT, so the flag is visible TIMEOUT cycles after start.
  assign expire = (state_q == WAIT_MLP) && enable_ai && !accept && (lat_cnt_q == TIMEOUT_LAST);
  assign timeout_d = timeout_q | expire;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (enable_ai && buffer_full) state_d = START;
      end
      START: begin
        state_d = WAIT_MLP;
      end
      WAIT_MLP: begin
        if (!enable_ai)  state_d = IDLE;
        else if (accept) state_d = DONE;
`ifdef INFER_TIMEOUT_EN
        else if (expire) state_d = HOLD;
`endif
      end
      DONE: begin
        state_d = HOLD;
      end
      HOLD: begin
        if (!enable_ai)                                 state_d = IDLE;
        else if ((hop_cnt_q >= HOP_C) && buffer_full)   state_d = START;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    lat_cnt_d = '0;
    if (state_q == START) begin
      lat_cnt_d = LAT_W'(1);
    end else if (state_q == WAIT_MLP) begin
      lat_cnt_d = (lat_cnt_q == {LAT_W{1'b1}}) ? lat_cnt_q : lat_cnt_q + 1'b1;
    end
  end

  // A note in the START cycle is already inside the latched window, so it is not counted.
  always_comb begin
    hop_cnt_d = hop_cnt_q;
    if ((state_d == IDLE) || !hop_counting) begin
      hop_cnt_d = 8'd0;
    end else if (load_new_note && (hop_cnt_q < HOP_C)) begin
      hop_cnt_d = hop_cnt_q + 8'd1;
    end
  end

  always_comb begin
    run_count_d = run_count_q;
    if (state_d == DONE) run_count_d = run_count_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      lat_cnt_q   <= '0;
      hop_cnt_q   <= 8'd0;
      run_count_q <= 8'd0;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      lat_cnt_q   <= lat_cnt_d;
      hop_cnt_q   <= hop_cnt_d;
      run_count_q <= run_count_d;
      start_q     <= (state_d == START);
      busy_q      <= (state_d == START) || (state_d == WAIT_MLP);
      ready_q     <= (state_d == DONE);
    end
  end

`ifdef INFER_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_d;
    end
  end
  assign timeout_err = timeout_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign start_mlp     = start_q;
  assign busy          = busy_q;
  assign emotion_ready = ready_q;
  assign run_count     = run_count_q;

endmodule
